// File: rtl/pipe_stage_reg_pkg.sv
// Shared types for the generic pipeline stage register: occupancy states and
// the LC-3b stage payload structs with their bubble / keep-mask constants.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

  function automatic logic [1:0] occ_count(input occ_state_t s);
    logic [1:0] n;
    n = 2'd0;
    case (s)
      ST_ONE:  n = 2'd1;
      ST_FULL: n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  typedef enum logic [3:0] {
    op_br   = 4'b0000,
    op_add  = 4'b0001,
    op_ldb  = 4'b0010,
    op_stb  = 4'b0011,
    op_jsr  = 4'b0100,
    op_and  = 4'b0101,
    op_ldr  = 4'b0110,
    op_str  = 4'b0111,
    op_rti  = 4'b1000,
    op_not  = 4'b1001,
    op_ldi  = 4'b1010,
    op_sti  = 4'b1011,
    op_jmp  = 4'b1100,
    op_shf  = 4'b1101,
    op_lea  = 4'b1110,
    op_trap = 4'b1111
  } lc3b_opcode_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] ir;
  } lc3b_if_id_t;

  typedef struct packed {
    logic [15:0]  pc;
    lc3b_opcode_t opcode;
    logic [2:0]   nzp;
    logic [2:0]   dr;
    logic [15:0]  sr1_data;
    logic [15:0]  sr2_data;
    logic [15:0]  imm;
    logic         ld_reg;
    logic         ld_cc;
    logic         mem_read;
    logic         mem_write;
  } lc3b_id_ex_t;

  typedef struct packed {
    logic [15:0]  pc;
    lc3b_opcode_t opcode;
    logic [2:0]   nzp;
    logic [2:0]   dr;
    logic [15:0]  alu_out;
    logic [15:0]  store_data;
    logic         ld_reg;
    logic         ld_cc;
    logic         mem_read;
    logic         mem_write;
  } lc3b_ex_mem_t;

  typedef struct packed {
    logic [15:0]  pc;
    lc3b_opcode_t opcode;
    logic [2:0]   dr;
    logic [15:0]  wb_data;
    logic         ld_reg;
    logic         ld_cc;
  } lc3b_mem_wb_t;

  // A BR with nzp=000 never branches, so an all-zero control word is a NOP.
  localparam lc3b_if_id_t IF_ID_BUBBLE = '0;
  localparam lc3b_if_id_t IF_ID_KEEP = '{pc: 16'hFFFF, ir: 16'h0000};

  localparam lc3b_id_ex_t ID_EX_BUBBLE = '{
    pc: 16'h0000, opcode: op_br, nzp: 3'b000, dr: 3'd0,
    sr1_data: 16'h0000, sr2_data: 16'h0000, imm: 16'h0000,
    ld_reg: 1'b0, ld_cc: 1'b0, mem_read: 1'b0, mem_write: 1'b0
  };
  localparam lc3b_id_ex_t ID_EX_KEEP = '{
    pc: 16'hFFFF, opcode: op_br, nzp: 3'b000, dr: 3'd0,
    sr1_data: 16'h0000, sr2_data: 16'h0000, imm: 16'h0000,
    ld_reg: 1'b0, ld_cc: 1'b0, mem_read: 1'b0, mem_write: 1'b0
  };

  localparam lc3b_ex_mem_t EX_MEM_BUBBLE = '{
    pc: 16'h0000, opcode: op_br, nzp: 3'b000, dr: 3'd0,
    alu_out: 16'h0000, store_data: 16'h0000,
    ld_reg: 1'b0, ld_cc: 1'b0, mem_read: 1'b0, mem_write: 1'b0
  };
  localparam lc3b_ex_mem_t EX_MEM_KEEP = '{
    pc: 16'hFFFF, opcode: op_br, nzp: 3'b000, dr: 3'd0,
    alu_out: 16'h0000, store_data: 16'h0000,
    ld_reg: 1'b0, ld_cc: 1'b0, mem_read: 1'b0, mem_write: 1'b0
  };

  localparam lc3b_mem_wb_t MEM_WB_BUBBLE = '{
    pc: 16'h0000, opcode: op_br, dr: 3'd0, wb_data: 16'h0000,
    ld_reg: 1'b0, ld_cc: 1'b0
  };
  localparam lc3b_mem_wb_t MEM_WB_KEEP = '{
    pc: 16'hFFFF, opcode: op_br, dr: 3'd0, wb_data: 16'h0000,
    ld_reg: 1'b0, ld_cc: 1'b0
  };

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Unsigned event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] MAX = {W{1'b1}};
  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline stage register: valid/ready handshake with a 2-entry skid
// buffer, flush with optional bubble injection, and saturating perf counters.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned       DATA_W      = 64,
  parameter logic [DATA_W-1:0] BUBBLE      = '0,
  parameter logic [DATA_W-1:0] KEEP_MASK   = '0,
  parameter bit                EMIT_BUBBLE = 1'b1,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              iValid,
  output logic              oReady,
  input  logic [DATA_W-1:0] iData,
  input  logic              iFlush,
  output logic              oValid,
  input  logic              iReady,
  output logic [DATA_W-1:0] oData,
  output logic [1:0]        oCount,
  output logic [CNT_W-1:0]  oStallCnt,
  output logic [CNT_W-1:0]  oFlushCnt
);

  occ_state_t        state_q;
  occ_state_t        state_n;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] main_n;
  logic [DATA_W-1:0] skid_q;
  logic [DATA_W-1:0] skid_n;
  logic              ready_q;
  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] bubble_word;

  assign oValid      = (state_q != ST_EMPTY);
  assign oReady      = ready_q;
  assign oData       = main_q;
  assign oCount      = occ_count(state_q);
  assign in_fire     = iValid && ready_q;
  assign out_fire    = oValid && iReady;
  assign bubble_word = (BUBBLE & ~KEEP_MASK) | (iData & KEEP_MASK);

  // Flush overrides every transfer; entries that stay unoccupied hold their value.
  always_comb begin
    state_n = state_q;
    main_n  = main_q;
    skid_n  = skid_q;
    if (iFlush) begin
      if (EMIT_BUBBLE) begin
        state_n = ST_ONE;
        main_n  = bubble_word;
      end else begin
        state_n = ST_EMPTY;
      end
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            main_n  = iData;
            state_n = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_n = iData;
          end else if (in_fire) begin
            skid_n  = iData;
            state_n = ST_FULL;
          end else if (out_fire) begin
            state_n = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_n  = skid_q;
            state_n = ST_ONE;
          end
        end
        default: state_n = ST_EMPTY;
      endcase
    end
  end

  // Ready is registered from the next state so iReady never reaches oReady combinationally.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_n;
      main_q  <= main_n;
      skid_q  <= skid_n;
      ready_q <= (state_n != ST_FULL);
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .Clk    (Clk),
    .nReset (nReset),
    .inc    (oValid && !iReady),
    .clear  (1'b0),
    .count  (oStallCnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .Clk    (Clk),
    .nReset (nReset),
    .inc    (iFlush),
    .clear  (1'b0),
    .count  (oFlushCnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: two instances (bubble / no-bubble flush)
// driven in parallel and compared every cycle against a queue-based model.
module tb_pipe_stage_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;
  localparam logic [DW-1:0] BUB  = 32'h0000_0000;
  localparam logic [DW-1:0] KEEP = 32'h0000_FFFF;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          nReset = 1'b1;
  logic          iValid = 1'b0;
  logic [DW-1:0] iData = '0;
  logic          iFlush = 1'b0;
  logic          iReady = 1'b0;

  logic          oReady1, oValid1, oReady2, oValid2;
  logic [DW-1:0] oData1, oData2;
  logic [1:0]    oCount1, oCount2;
  logic [CW-1:0] oStall1, oFlush1, oStall2, oFlush2;

  int total = 0;
  int bad = 0;

  always #5 Clk = ~Clk;

  pipe_stage_reg #(
    .DATA_W(DW), .BUBBLE(BUB), .KEEP_MASK(KEEP), .EMIT_BUBBLE(1'b1), .CNT_W(CW)
  ) dut_bub (
    .Clk(Clk), .nReset(nReset), .iValid(iValid), .oReady(oReady1), .iData(iData),
    .iFlush(iFlush), .oValid(oValid1), .iReady(iReady), .oData(oData1),
    .oCount(oCount1), .oStallCnt(oStall1), .oFlushCnt(oFlush1)
  );

  pipe_stage_reg #(
    .DATA_W(DW), .BUBBLE(BUB), .KEEP_MASK(KEEP), .EMIT_BUBBLE(1'b0), .CNT_W(CW)
  ) dut_nob (
    .Clk(Clk), .nReset(nReset), .iValid(iValid), .oReady(oReady2), .iData(iData),
    .iFlush(iFlush), .oValid(oValid2), .iReady(iReady), .oData(oData2),
    .oCount(oCount2), .oStallCnt(oStall2), .oFlushCnt(oFlush2)
  );

  // Reference model: each stage is just a FIFO of at most two beats.
  logic [DW-1:0] q1[$];
  logic [DW-1:0] q2[$];
  int m_stall1 = 0;
  int m_stall2 = 0;
  int m_flush = 0;
  bit v1, v2, r1, r2;

  task automatic checkOutput(input string name, input logic [DW-1:0] act,
                             input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      q1.delete();
      q2.delete();
      m_stall1 = 0;
      m_stall2 = 0;
      m_flush = 0;
    end else begin
      v1 = (q1.size() != 0);
      v2 = (q2.size() != 0);
      r1 = (q1.size() < 2);
      r2 = (q2.size() < 2);
      if (v1 && !iReady && m_stall1 < CMAX) m_stall1++;
      if (v2 && !iReady && m_stall2 < CMAX) m_stall2++;
      if (iFlush) begin
        if (m_flush < CMAX) m_flush++;
        q1.delete();
        q1.push_back((BUB & ~KEEP) | (iData & KEEP));
        q2.delete();
      end else begin
        if (v1 && iReady) void'(q1.pop_front());
        if (iValid && r1) q1.push_back(iData);
        if (v2 && iReady) void'(q2.pop_front());
        if (iValid && r2) q2.push_back(iData);
      end
    end
  end

  // Monitor: compares whatever the DUTs present against the head of the model queues.
  always @(negedge Clk) begin
    if (nReset) begin
      checkOutput("valid1", {31'b0, oValid1}, {31'b0, q1.size() != 0});
      checkOutput("ready1", {31'b0, oReady1}, {31'b0, q1.size() < 2});
      checkOutput("count1", {30'b0, oCount1}, q1.size());
      checkOutput("stall1", {28'b0, oStall1}, m_stall1);
      checkOutput("flush1", {28'b0, oFlush1}, m_flush);
      if (q1.size() != 0) checkOutput("data1", oData1, q1[0]);
      checkOutput("valid2", {31'b0, oValid2}, {31'b0, q2.size() != 0});
      checkOutput("ready2", {31'b0, oReady2}, {31'b0, q2.size() < 2});
      checkOutput("count2", {30'b0, oCount2}, q2.size());
      checkOutput("stall2", {28'b0, oStall2}, m_stall2);
      checkOutput("flush2", {28'b0, oFlush2}, m_flush);
      if (q2.size() != 0) checkOutput("data2", oData2, q2[0]);
    end
  end

  task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input bit f,
                               input bit r);
    iValid = v;
    iData  = d;
    iFlush = f;
    iReady = r;
    @(posedge Clk);
    #1;
  endtask

  task automatic applyReset();
    iValid = 1'b0;
    iFlush = 1'b0;
    iReady = 1'b0;
    nReset = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    nReset = 1'b1;
  endtask

  initial begin
    #1;
    applyReset();
    checkOutput("rst_valid", {31'b0, oValid1}, 0);
    checkOutput("rst_ready", {31'b0, oReady1}, 1);
    checkOutput("rst_count", {30'b0, oCount1}, 0);
    checkOutput("rst_data", oData1, BUB);
    checkOutput("rst_stall", {28'b0, oStall1}, 0);
    checkOutput("rst_flush", {28'b0, oFlush1}, 0);

    applyStimulus(1, 32'h1234, 0, 1);
    checkOutput("single_valid", {31'b0, oValid1}, 1);
    checkOutput("single_data", oData1, 32'h1234);
    checkOutput("single_count", {30'b0, oCount1}, 1);
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("single_gone", {31'b0, oValid1}, 0);

    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1, i, 0, 1);
      checkOutput("stream_data", oData1, i);
      checkOutput("stream_ready", {31'b0, oReady1}, 1);
    end
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("stream_stall", {28'b0, oStall1}, 0);

    applyStimulus(1, 32'hA, 0, 0);
    applyStimulus(1, 32'hB, 0, 0);
    checkOutput("skid_count", {30'b0, oCount1}, 2);
    checkOutput("skid_ready", {31'b0, oReady1}, 0);
    applyStimulus(1, 32'hC, 0, 0);
    checkOutput("skid_refuse", {30'b0, oCount1}, 2);
    checkOutput("skid_head", oData1, 32'hA);
    applyStimulus(1, 32'hC, 0, 1);
    checkOutput("skid_second", oData1, 32'hB);
    applyStimulus(1, 32'hC, 0, 1);
    checkOutput("skid_third", oData1, 32'hC);
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("skid_drained", {31'b0, oValid1}, 0);
    checkOutput("skid_stallcnt", {28'b0, oStall1}, 2);

    applyReset();
    applyStimulus(1, 32'h1, 0, 0);
    applyStimulus(1, 32'h2, 0, 0);
    applyStimulus(1, 32'hABCD_1234, 1, 0);
    checkOutput("fl_valid", {31'b0, oValid1}, 1);
    checkOutput("fl_data", oData1, 32'h0000_1234);
    checkOutput("fl_count", {30'b0, oCount1}, 1);
    checkOutput("fl_cnt", {28'b0, oFlush1}, 1);
    checkOutput("fl_ready", {31'b0, oReady1}, 1);
    checkOutput("fl0_valid", {31'b0, oValid2}, 0);
    checkOutput("fl0_count", {30'b0, oCount2}, 0);
    checkOutput("fl0_ready", {31'b0, oReady2}, 1);
    applyStimulus(0, 32'h5555_AAAA, 1, 0);
    checkOutput("fl2_data", oData1, 32'h0000_AAAA);
    checkOutput("fl2_count", {30'b0, oCount1}, 1);
    checkOutput("fl2_cnt", {28'b0, oFlush1}, 2);
    applyStimulus(0, 32'h0, 0, 1);

    applyReset();
    applyStimulus(1, 32'h77, 0, 0);
    repeat (20) applyStimulus(0, 32'h0, 0, 0);
    checkOutput("sat_stall", {28'b0, oStall1}, CMAX);
    applyStimulus(0, 32'h0, 0, 0);
    checkOutput("sat_hold", {28'b0, oStall1}, CMAX);
    checkOutput("sat_data", oData1, 32'h77);

    applyReset();
    applyStimulus(1, 32'h11, 0, 0);
    applyStimulus(1, 32'h22, 0, 0);
    checkOutput("ar_full", {30'b0, oCount1}, 2);
    #2;
    nReset = 1'b0;
    #1;
    checkOutput("ar_valid", {31'b0, oValid1}, 0);
    checkOutput("ar_ready", {31'b0, oReady1}, 1);
    checkOutput("ar_data", oData1, BUB);
    checkOutput("ar_count", {30'b0, oCount1}, 0);
    @(posedge Clk);
    #1;
    nReset = 1'b1;
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("ar_nostale", {31'b0, oValid1}, 0);
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("ar_nostale2", {31'b0, oValid1}, 0);

    applyReset();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom % 4) != 0, $urandom, ($urandom % 16) == 0,
                    ($urandom % 3) != 0);
    end
    applyStimulus(0, 32'h0, 0, 1);
    applyStimulus(0, 32'h0, 0, 1);
    applyStimulus(0, 32'h0, 0, 1);
    checkOutput("final_empty", {31'b0, oValid1}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register that replaces the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries an opaque packed payload of DATA_W bits between stages.
- Adds a valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered.
- Adds flush with optional bubble injection (selected fields preserved per KEEP_MASK) and saturating stall/flush counters for performance analysis.

Parameters:
- DATA_W, 64, payload width in bits (packed stage struct)
- BUBBLE, '0, DATA_W-bit payload injected on flush (e.g. encodes op_br with nzp=000, i.e. a NOP)
- KEEP_MASK, '0, DATA_W-bit mask; bits set here take iData on a bubble instead of BUBBLE (e.g. PC field)
- EMIT_BUBBLE, 1, 1: flush leaves one bubble beat valid at output; 0: flush empties the stage
- CNT_W, 16, width of the saturating performance counters

Ports:
- Clk  in  1  rising-edge clock
- nReset  in  1  asynchronous active-low reset
- iValid  in  1  upstream beat valid
- oReady  out  1  stage can accept a beat (registered)
- iData  in  DATA_W  upstream payload
- iFlush  in  1  synchronous kill of all held and incoming beats
- oValid  out  1  output beat valid
- iReady  in  1  downstream accepts the beat
- oData  out  DATA_W  output payload (main entry)
- oCount  out  2  occupancy, 0..2
- oStallCnt  out  CNT_W  cycles with oValid && !iReady, saturating
- oFlushCnt  out  CNT_W  flush events, saturating

Behaviour:
- Reset (nReset=0, asynchronous):
  - State EMPTY; oValid=0, oReady=1, oCount=0.
  - oData=BUBBLE; skid entry=BUBBLE.
  - Both counters 0.
  - Reset mid-transfer discards all beats immediately.
- Handshake rules:
  - in_fire = iValid && oReady.
  - out_fire = oValid && iReady.
  - Upstream may drop iValid at any time; the stage never assumes persistence.
  - oData is stable while oValid && !iReady.
- State machine on occupancy:
  - EMPTY: oValid=0. in_fire loads main -> ONE.
  - ONE: oValid=1.
    - in_fire && out_fire: main <= iData, stay ONE.
    - in_fire only: skid <= iData -> FULL.
    - out_fire only: -> EMPTY.
  - FULL: oReady=0.
    - out_fire: main <= skid -> ONE.
- oReady is a register: 1 in EMPTY/ONE, 0 in FULL. There is no combinational path iReady -> oReady.
- Latency: 1 cycle from in_fire to oValid when empty. Throughput: 1 beat/cycle sustained with iReady=1.
- Ordering: strict FIFO, no beat duplicated or lost absent flush.
- Flush (iFlush=1 at edge; highest priority over all transfers):
  - All held beats are discarded, and the same-cycle in_fire beat is discarded as a payload.
  - EMIT_BUBBLE=1: next state ONE. main <= (BUBBLE & ~KEEP_MASK) | (iData & KEEP_MASK); KEEP_MASK bits are taken from iData regardless of iValid.
  - EMIT_BUBBLE=0: next state EMPTY.
  - oReady=1 after flush.
  - oFlushCnt += 1 per flush cycle.
  - Back-to-back flushes each produce one bubble (no accumulation).
- Counters:
  - Unsigned; stick at 2^CNT_W-1.
  - oStallCnt samples oValid && !iReady before the edge, including cycles with flush.
- Unoccupied entries are not updated (low power); their contents are don't-care.

Decomposition:
- The stage payload structs (lc3b_if_id_t, lc3b_id_ex_t, ...) and their BUBBLE/KEEP_MASK constants go in lc3b_types.
- The old per-stage registers become instances with DATA_W=$bits(struct).
- One natural sub-module: sat_counter (parameter W, inputs inc/clear, saturating output), instantiated twice.

Test Plan:
- Reset, then iValid=1 with iData=0x1234 and iReady=1 for one cycle -> next cycle oValid=1, oData=0x1234, oCount=1; cycle after, oValid=0.
- Stream 0x1..0x8 with iReady=1 -> outputs 0x1..0x8 in order on consecutive cycles, oReady stays 1, oStallCnt=0.
- Hold iReady=0 and push 0xA, 0xB -> oCount=2, oReady=0, 0xC is refused. Release iReady -> 0xA, 0xB, then 0xC delivered in order; oStallCnt equals the stall cycle count.
- FULL with EMIT_BUBBLE=1, BUBBLE=0, KEEP_MASK=0xFFFF, iData=0xABCD1234, iFlush=1 -> oValid=1, oData=0x00001234, oCount=1, oFlushCnt=1. The same test with EMIT_BUBBLE=0 -> oValid=0, oCount=0.
- CNT_W=4, iReady=0 held 20 cycles with a beat valid -> oStallCnt=15 and holds there.
- Assert nReset=0 asynchronously mid-stream while FULL -> oValid=0, oReady=1, oData=BUBBLE before the next edge; no stale beat appears after reset releases.
